// File: rtl/fb_pixel_reader.sv
// Framebuffer read side: prefetches packed 5 x RGB111 words and emits one pixel per strobe.
// Optional FB_READER_UNDERRUN_COUNT_EN adds a saturating underrun_count output.
module fb_pixel_reader #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = 18,
  parameter int FRAME_WORDS = 82944
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          frame_start,
  input  logic                          display_en,
  input  logic                          pixel_strobe,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [ADDR_W-1:0]             req_addr,
  input  logic                          rsp_valid,
  input  logic [15:0]                   rsp_data,
  output logic [2:0]                    rgb_111_out,
  output logic                          underrun,
`ifdef FB_READER_UNDERRUN_COUNT_EN
  output logic [15:0]                   underrun_count,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int DW = LW + 4;

  logic [14:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] inflight;
  logic [DW-1:0] discard;
  logic [14:0]   cur_word;
  logic          cur_valid;
  logic [2:0]    idx;
  logic          req_en;

  logic          hs, push, drop, pop, pix, take, blank_px;
  logic [14:0]   word;
  logic [2:0]    pix_val;
  logic [LW:0]   outstanding;
  logic          rsp_unused;

  assign rsp_unused  = rsp_data[15];
  assign outstanding = (LW+1)'(fifo_level) + (LW+1)'(inflight);
  assign req_valid   = req_en && !frame_start && (outstanding < (LW+1)'(FIFO_DEPTH));
  assign hs          = req_valid && req_ready;
  assign drop        = rsp_valid && (discard != '0);
  assign push        = rsp_valid && (discard == '0);
  assign pop         = !cur_valid && (fifo_level != '0);
  // A word popped this clk is usable by a coincident strobe (no bubble).
  assign word        = cur_valid ? cur_word : mem[rd_ptr];
  assign pix         = pixel_strobe && display_en;
  assign take        = pix && (cur_valid || pop) && !underrun;
  assign blank_px    = !frame_start && pix && !take;

  always_comb begin
    pix_val = word[2:0];
    case (idx)
      3'd0:    pix_val = word[2:0];
      3'd1:    pix_val = word[5:3];
      3'd2:    pix_val = word[8:6];
      3'd3:    pix_val = word[11:9];
      default: pix_val = word[14:12];
    endcase
  end

  always_ff @(posedge clk) begin
    if (push && !frame_start) mem[wr_ptr] <= rsp_data[14:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_en      <= 1'b0;
      req_addr    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      inflight    <= '0;
      discard     <= '0;
      cur_word    <= '0;
      cur_valid   <= 1'b0;
      idx         <= '0;
      rgb_111_out <= '0;
      underrun    <= 1'b0;
    end else begin
      req_en <= 1'b1;
      if (frame_start) begin
        req_addr    <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        fifo_level  <= '0;
        inflight    <= '0;
        cur_valid   <= 1'b0;
        idx         <= '0;
        rgb_111_out <= '0;
        underrun    <= 1'b0;
        // A response landing now retires one of the reads still owed by the arbiter.
        discard     <= discard + DW'(inflight) - DW'(rsp_valid);
      end else begin
        if (hs)
          req_addr <= (req_addr == ADDR_W'(FRAME_WORDS - 1)) ? '0 : req_addr + 1'b1;
        inflight   <= inflight + LW'(hs) - LW'(push);
        if (drop) discard <= discard - 1'b1;
        if (push) wr_ptr  <= wr_ptr + 1'b1;
        if (pop)  rd_ptr  <= rd_ptr + 1'b1;
        fifo_level <= fifo_level + LW'(push) - LW'(pop);
        if (pop) begin
          cur_word  <= mem[rd_ptr];
          cur_valid <= 1'b1;
        end
        if (take) begin
          rgb_111_out <= pix_val;
          if (idx == 3'd4) begin
            idx       <= '0;
            cur_valid <= 1'b0;
          end else begin
            idx <= idx + 3'd1;
          end
        end else if (pix) begin
          rgb_111_out <= '0;
          underrun    <= 1'b1;
        end else if (pixel_strobe) begin
          rgb_111_out <= '0;
        end
      end
    end
  end

`ifdef FB_READER_UNDERRUN_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      underrun_count <= '0;
    else if (blank_px && underrun_count != 16'hFFFF)
      underrun_count <= underrun_count + 16'd1;
  end
`else
  logic blank_unused;
  assign blank_unused = blank_px;
`endif

endmodule

// File: tb/tb_fb_pixel_reader.sv
// Directed bench for fb_pixel_reader with an in-order, variable-latency responder model.
// Uses a short FRAME_WORDS so the address wrap is reachable in a short run.
module tb_fb_pixel_reader;
  localparam int FW = 13;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          reset_n, frame_start, display_en, pixel_strobe;
  logic          req_valid, req_ready, rsp_valid;
  logic [AW-1:0] req_addr;
  logic [15:0]   rsp_data;
  logic [2:0]    rgb_111_out;
  logic          underrun;
  logic [2:0]    fifo_level;
`ifdef FB_READER_UNDERRUN_COUNT_EN
  logic [15:0]   underrun_count;
`endif

  always #5 clk = ~clk;

  fb_pixel_reader #(.FIFO_DEPTH(4), .ADDR_W(AW), .FRAME_WORDS(FW)) dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .display_en(display_en),
    .pixel_strobe(pixel_strobe), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rgb_111_out(rgb_111_out), .underrun(underrun),
`ifdef FB_READER_UNDERRUN_COUNT_EN
    .underrun_count(underrun_count),
`endif
    .fifo_level(fifo_level)
  );

  int total = 0;
  int bad   = 0;

  // Responder: word chosen by {epoch, addr[1:0]} at handshake time, returned in order.
  logic [15:0]   word_tbl [8];
  logic [15:0]   data_q [$];
  int            iss_q [$];
  logic [AW-1:0] hs_log [$];
  int            cyc = 0;
  int            rsp_lat = 0;
  logic          epoch = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q.delete();
      iss_q.delete();
      rsp_valid <= 1'b0;
      rsp_data  <= 16'h0;
    end else begin
      cyc = cyc + 1;
      if (rsp_valid) begin
        void'(data_q.pop_front());
        void'(iss_q.pop_front());
      end
      if (req_valid && req_ready) begin
        data_q.push_back(word_tbl[{epoch, req_addr[1:0]}]);
        iss_q.push_back(cyc);
        hs_log.push_back(req_addr);
      end
      if (data_q.size() > 0 && (cyc - iss_q[0]) >= rsp_lat) begin
        rsp_valid <= 1'b1;
        rsp_data  <= data_q[0];
      end else begin
        rsp_valid <= 1'b0;
        rsp_data  <= 16'h0;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic strobe(input logic de);
    @(negedge clk);
    display_en   = de;
    pixel_strobe = 1'b1;
    @(negedge clk);
    pixel_strobe = 1'b0;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  typedef struct {
    logic       de;
    logic [2:0] rgb;
    logic       und;
  } vec_t;
  vec_t vecs [21];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int n;
    word_tbl[0] = 16'h8A4C;  // 4,1,1,5,0 (bit 15 must be ignored)
    word_tbl[1] = 16'h3977;  // 7,6,5,4,3
    word_tbl[2] = 16'h58D1;  // 1,2,3,4,5
    word_tbl[3] = 16'h21C0;  // 0,0,7,0,2
    word_tbl[4] = 16'h0006;  // 6,0,0,0,0
    word_tbl[5] = 16'h7FFF;  // 7,7,7,7,7
    word_tbl[6] = 16'h1234;
    word_tbl[7] = 16'h5678;

    vecs[0]  = '{1'b1, 3'd4, 1'b0}; vecs[1]  = '{1'b1, 3'd1, 1'b0};
    vecs[2]  = '{1'b1, 3'd1, 1'b0}; vecs[3]  = '{1'b1, 3'd5, 1'b0};
    vecs[4]  = '{1'b1, 3'd0, 1'b0}; vecs[5]  = '{1'b1, 3'd7, 1'b0};
    vecs[6]  = '{1'b1, 3'd6, 1'b0}; vecs[7]  = '{1'b0, 3'd0, 1'b0};
    vecs[8]  = '{1'b1, 3'd5, 1'b0}; vecs[9]  = '{1'b1, 3'd4, 1'b0};
    vecs[10] = '{1'b1, 3'd3, 1'b0}; vecs[11] = '{1'b1, 3'd1, 1'b0};
    vecs[12] = '{1'b1, 3'd2, 1'b0}; vecs[13] = '{1'b1, 3'd3, 1'b0};
    vecs[14] = '{1'b1, 3'd4, 1'b0}; vecs[15] = '{1'b1, 3'd5, 1'b0};
    vecs[16] = '{1'b1, 3'd0, 1'b0}; vecs[17] = '{1'b1, 3'd0, 1'b0};
    vecs[18] = '{1'b1, 3'd7, 1'b0}; vecs[19] = '{1'b1, 3'd0, 1'b0};
    vecs[20] = '{1'b1, 3'd2, 1'b0};

    reset_n = 1'b0; frame_start = 1'b0; display_en = 1'b0; pixel_strobe = 1'b0;
    req_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_rgb", int'(rgb_111_out), 0);
    chk("reset_underrun", int'(underrun), 0);
    chk("reset_level", int'(fifo_level), 0);
    chk("reset_req_valid", int'(req_valid), 0);
    chk("reset_req_addr", int'(req_addr), 0);

    // Prefetch: FIFO fills to 4 and the current-word register holds one more.
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("fill_level", int'(fifo_level), 4);
    chk("fill_req_valid", int'(req_valid), 0);
    chk("fill_req_count", int'(hs_log.size()), 5);
    chk("fill_last_addr", int'(hs_log[hs_log.size()-1]), 4);
    chk("fill_req_addr", int'(req_addr), 5);

    for (int i = 0; i < 21; i++) begin
      strobe(vecs[i].de);
      chk($sformatf("pix%0d_rgb", i), int'(rgb_111_out), int'(vecs[i].rgb));
      chk($sformatf("pix%0d_underrun", i), int'(underrun), int'(vecs[i].und));
    end

    // Starvation: no requests accepted after a flush.
    req_ready = 1'b0;
    repeat (4) @(negedge clk);
    pulse_frame();
    chk("flush_req_addr", int'(req_addr), 0);
    chk("flush_level", int'(fifo_level), 0);
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1);
      chk($sformatf("starve%0d_rgb", i), int'(rgb_111_out), 0);
      chk($sformatf("starve%0d_underrun", i), int'(underrun), 1);
    end
    pulse_frame();
    chk("restart_underrun", int'(underrun), 0);
    chk("restart_req_addr", int'(req_addr), 0);

    // Two reads outstanding across frame_start must be dropped.
    rsp_lat = 8;
    base = hs_log.size();
    @(negedge clk); req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); req_ready = 1'b0;
    chk("stale_reads", int'(hs_log.size()) - base, 2);
    pulse_frame();
    chk("stale_req_addr", int'(req_addr), 0);
    epoch = 1'b1;
    base = hs_log.size();
    req_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("new_first_addr", int'(hs_log[base]), 0);
    strobe(1'b1); chk("new_pix0", int'(rgb_111_out), 6);
    strobe(1'b1); chk("new_pix1", int'(rgb_111_out), 0);
    strobe(1'b1); strobe(1'b1); strobe(1'b1);
    strobe(1'b1); chk("new_pix5", int'(rgb_111_out), 7);
    chk("new_underrun", int'(underrun), 0);

    // Address wrap: FW-1 -> 0 -> 1 within one frame.
    rsp_lat = 0;
    n = 0;
    while ((int'(hs_log.size()) - base) < FW + 2 && n < 400) begin
      strobe(1'b1);
      n++;
    end
    if ((int'(hs_log.size()) - base) >= FW + 2) begin
      chk("wrap_last", int'(hs_log[base+FW-1]), FW - 1);
      chk("wrap_zero", int'(hs_log[base+FW]), 0);
      chk("wrap_one", int'(hs_log[base+FW+1]), 1);
    end else begin
      chk("wrap_reached", int'(hs_log.size()) - base, FW + 2);
    end
    chk("wrap_underrun", int'(underrun), 0);

`ifdef FB_READER_UNDERRUN_COUNT_EN
    @(negedge clk);
    reset_n = 1'b0; req_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("cnt_reset", int'(underrun_count), 0);
    repeat (7) strobe(1'b1);
    chk("cnt_seven", int'(underrun_count), 7);
    pulse_frame();
    chk("cnt_kept", int'(underrun_count), 7);
    repeat (3) strobe(1'b1);
    chk("cnt_ten", int'(underrun_count), 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
